piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
- Parallel-in, serial-out transmitter. It is the driving end of the 1-bit serial data line that the team's D-flip-flop capture stages sample.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clock.
- Drives a frame-valid strobe alongside the data and pulses done on the final bit.
- Sits between a parallel producer (counter, register file) and a serial link or deserializer.

Parameters:
- WIDTH, 8, data word width in bits; legal range is ≥2.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rest  input  1  asynchronous active-low reset; rest=0 clears all state immediately, independent of clk.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  parallel word; sampled only on an accept edge.
- sout  output  1  serial data bit, registered.
- sframe  output  1  high while sout carries a valid frame bit, registered.
- done  output  1  one-cycle pulse, high during the last bit of a frame.

Behaviour:
- Reset (rest=0, async): state=IDLE, shift register=0, bit count=0, sout=0, sframe=0, done=0. in_ready reads 1 after reset, since it is combinational on state.
- Accept: occurs on a posedge where in_valid=1 and in_ready=1. in_data is loaded into the shift register.
- in_ready=1 when state=IDLE, or when state=SHIFT and the last bit is on sout (back-to-back support). Otherwise in_ready=0.
- FSM states:
  - IDLE: sframe=0, sout=0. On accept → SHIFT.
  - SHIFT: sframe=1. Each posedge shifts left by one and increments the count.
  - After WIDTH bits, with no accept → IDLE.
  - On the last-bit cycle, if an accept occurs → stay in SHIFT and reload, so the next frame follows with no gap.
- Latency: word accepted at edge N gives MSB on sout/sframe=1 from edge N through N+1. Bit i (MSB = i=0) is driven in cycle N+1+i. The LSB appears in cycle N+WIDTH, with done=1 in that same cycle.
- done: high for exactly one cycle per frame, coincident with the final bit. Never high in IDLE.
- in_valid while busy (not the last bit): ignored. No capture, no effect on the current frame. The producer must hold the word.
- in_data changing while busy: no effect.
- Reset mid-frame: the frame is aborted immediately. Outputs clear within the same cycle (async), and no done pulse is issued. After rest releases, the block is in IDLE with in_ready=1.
- No X propagation: sout=0 whenever sframe=0.

Optional Feature:
- Macro: PISO_TX_PARITY_EN.
- Defined:
  - After the LSB, one extra cycle with sframe=1 carries even parity, i.e. XOR of the captured word.
  - done moves to the parity cycle, so frame length is WIDTH+1.
  - The back-to-back accept window moves to the parity cycle.
  - The parity bit is computed at load time and stored.
- Undefined: frame length is WIDTH, with no parity register or logic.

Decomposition:
- Package piso_tx_pkg holds:
  - the state enum (IDLE, SHIFT), 1 bit;
  - the frame-length constant function (WIDTH, or WIDTH+1 under PISO_TX_PARITY_EN);
  - the last-bit index helper.
- One sub-module, piso_shift_reg: a WIDTH-bit load/shift-left register with async active-low clear on rest, outputting its MSB.
- The FSM, counter and handshake stay in piso_tx.

Test Plan:
- Reset: hold rest=0 with random inputs and clk running → sout=0, sframe=0, done=0, in_ready=1. Then pulse rest=0 asynchronously between edges → outputs clear without a clock edge.
- Single frame: accept 8'hA5 at edge N → sout sequence 1,0,1,0,0,1,0,1 in cycles N+1..N+8. sframe=1 for exactly 8 cycles, done=1 only in cycle N+8, in_ready=0 in cycles N+1..N+7.
- Back-to-back: 8'hA5 then 8'h3C with in_valid held → 16 contiguous sframe cycles with sout = A5 bits then 3C bits. done pulses in cycles N+8 and N+16; no IDLE gap.
- Busy ignore: accept 8'hFF, then present in_valid with 8'h00 in cycles N+2..N+6 → transmitted bits remain all 1. 8'h00 is accepted only at the last-bit edge if still valid.
- Reset mid-frame: accept 8'hC3, drive rest=0 in cycle N+4 → sframe/sout drop immediately, no done. After release, accept 8'h81 → a clean frame 1,0,0,0,0,0,0,1.
- Parity (PISO_TX_PARITY_EN): 8'hA5 → 9 frame bits, last = 0. 8'hA4 → last = 1. done moves to cycle N+9.

Source files
------------

// File: rtl/piso_tx_pkg.sv
// Shared types and frame-geometry helpers for the piso_tx serializer.
// PISO_TX_PARITY_EN appends one even-parity bit to every frame.
package piso_tx_pkg;

  typedef logic [0:0] state_t;

  localparam state_t StIdle  = 1'b0;
  localparam state_t StShift = 1'b1;

  // Number of serial bits per frame, including the optional parity bit.
  function automatic int unsigned frame_len(input int unsigned width);
`ifdef PISO_TX_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  // Index of the final bit of a frame; done and the reload window sit here.
  function automatic int unsigned last_idx(input int unsigned width);
    return frame_len(width) - 1;
  endfunction

endpackage

// File: rtl/piso_tx_if.sv
// Parallel-side valid/ready handshake feeding the piso_tx serializer.
interface piso_tx_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/piso_shift_reg.sv
// WIDTH-bit load / shift-left register with async active-low clear; exposes its MSB.
module piso_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] data_q;

  // Load wins over shift so a back-to-back reload replaces the drained word.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= din;
    end else if (shift) begin
      data_q <= {data_q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = data_q[WIDTH-1];

endmodule

// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter: MSB first, frame strobe and last-bit done pulse.
// Define PISO_TX_PARITY_EN to append an even-parity bit after the LSB.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic       clk,
  input  logic       rest,
  piso_tx_if.slave   in_if,
  output logic       sout,
  output logic       sframe,
  output logic       done
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(last_idx(WIDTH));

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load;
  logic             shift;
  logic             accept;
  logic             last_bit;
  logic             sr_msb;
  logic             data_bit;

  assign last_bit       = (state_q == StShift) && (cnt_q == LastCnt);
  assign in_if.in_ready = (state_q == StIdle) || last_bit;
  assign accept         = in_if.in_valid && in_if.in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    if (accept) begin
      state_d = StShift;
      cnt_d   = '0;
      load    = 1'b1;
    end else if (state_q == StShift) begin
      shift = 1'b1;
      if (last_bit) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  piso_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_reg (
    .clk   (clk),
    .rest  (rest),
    .load  (load),
    .shift (shift),
    .din   (in_if.in_data),
    .msb   (sr_msb)
  );

`ifdef PISO_TX_PARITY_EN
  localparam logic [CNT_W-1:0] ParityCnt = CNT_W'(WIDTH);

  logic parity_q;

  // Parity is captured with the word so later in_data changes cannot affect it.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      parity_q <= 1'b0;
    end else if (load) begin
      parity_q <= ^in_if.in_data;
    end
  end

  assign data_bit = (cnt_q == ParityCnt) ? parity_q : sr_msb;
`else
  assign data_bit = sr_msb;
`endif

  assign sframe = (state_q == StShift);
  assign sout   = sframe && data_bit;
  assign done   = last_bit;

endmodule

// File: tb/tb_piso_tx.sv
// Directed self-checking bench for piso_tx (works with or without PISO_TX_PARITY_EN).
module tb_piso_tx;

`ifdef PISO_TX_PARITY_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  logic clk;
  logic rest;
  logic sout;
  logic sframe;
  logic done;

  int checks;
  int failures;

  piso_tx_if #(.WIDTH(8)) bus ();

  piso_tx #(
    .WIDTH (8)
  ) dut (
    .clk    (clk),
    .rest   (rest),
    .in_if  (bus.slave),
    .sout   (sout),
    .sframe (sframe),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".sframe"}, {31'd0, sframe}, 32'd0);
    check({tag, ".sout"}, {31'd0, sout}, 32'd0);
    check({tag, ".done"}, {31'd0, done}, 32'd0);
    check({tag, ".ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  // Entered in the first cycle of a frame; returns in its last cycle without stepping.
  // From bit index valid_from onward in_valid is held high with nxt on in_data.
  task automatic check_frame(input string tag, input logic [7:0] word, input int valid_from,
                             input logic [7:0] nxt);
    logic exp_bit;
    for (int i = 0; i < FLEN; i++) begin
      if (i >= valid_from) begin
        bus.in_valid = 1'b1;
        bus.in_data  = nxt;
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
      end
      exp_bit = (i < 8) ? word[7-i] : ^word;
      check($sformatf("%s.sout[%0d]", tag, i), {31'd0, sout}, {31'd0, exp_bit});
      check($sformatf("%s.sframe[%0d]", tag, i), {31'd0, sframe}, 32'd1);
      check($sformatf("%s.done[%0d]", tag, i), {31'd0, done}, (i == FLEN - 1) ? 32'd1 : 32'd0);
      check($sformatf("%s.ready[%0d]", tag, i), {31'd0, bus.in_ready},
            (i == FLEN - 1) ? 32'd1 : 32'd0);
      if (i != FLEN - 1) step();
    end
  endtask

  task automatic send(input logic [7:0] word);
    bus.in_valid = 1'b1;
    bus.in_data  = word;
    step();
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rest         = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset held with random stimulus and the clock running.
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'($urandom);
      bus.in_data  = 8'($urandom);
      step();
      check_idle($sformatf("rst_hold%0d", i));
    end
    bus.in_valid = 1'b0;
    rest = 1'b1;
    step();
    check_idle("post_rst");

    // Single frame, then return to idle.
    send(8'hA5);
    check_frame("single", 8'hA5, FLEN, 8'h00);
    bus.in_valid = 1'b0;
    step();
    check_idle("single_end");

    // Back-to-back: in_valid held, second word taken on the last-bit edge.
    send(8'hA5);
    check_frame("b2b0", 8'hA5, 0, 8'h3C);
    step();
    check_frame("b2b1", 8'h3C, FLEN, 8'h00);
    step();
    check_idle("b2b_end");

    // Busy ignore: 00 offered mid-frame is only taken at the last bit.
    send(8'hFF);
    check_frame("busy", 8'hFF, 1, 8'h00);
    step();
    check_frame("busy_next", 8'h00, FLEN, 8'h00);
    step();
    check_idle("busy_end");

    // Async reset mid-frame: outputs clear between edges, no done afterward.
    send(8'hC3);
    bus.in_valid = 1'b0;
    step();
    step();
    step();
    check("mid.sframe_before", {31'd0, sframe}, 32'd1);
    #2;
    rest = 1'b0;
    #1;
    check_idle("mid_async");
    step();
    check_idle("mid_held");
    rest = 1'b1;
    for (int i = 0; i < FLEN; i++) begin
      step();
      check_idle($sformatf("mid_after%0d", i));
    end
    send(8'h81);
    check_frame("post_abort", 8'h81, FLEN, 8'h00);
    bus.in_valid = 1'b0;
    step();
    check_idle("post_abort_end");

    // Odd-weight word: parity bit 1 when the parity build is used.
    send(8'hA4);
    check_frame("a4", 8'hA4, FLEN, 8'h00);
    bus.in_valid = 1'b0;
    step();
    check_idle("a4_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
